pit_count: RTL

PIT_COUNT -- requirements
Module: pit_count

---
 rtl/pit_pkg.sv | 16 +
 rtl/pit_prescale.sv | 28 ++
 rtl/pit_count.sv | 79 +++++++
 3 files changed

// File: rtl/pit_pkg.sv
// Shared constants and helpers for the programmable interval timer.
package pit_pkg;

  localparam int         PRE_CNT_W   = 15;
  localparam logic [3:0] MAX_PRE_EXP = 4'd15;

  // Divisor minus one for a prescale exponent, i.e. 2^exp - 1.
  function automatic logic [PRE_CNT_W-1:0] div_m1(input logic [3:0] exp);
    logic [3:0]         e;
    logic [PRE_CNT_W:0] one_hot;
    e       = (exp > MAX_PRE_EXP) ? MAX_PRE_EXP : exp;
    one_hot = (PRE_CNT_W+1)'(1) << e;
    return PRE_CNT_W'(one_hot - 1'b1);
  endfunction

endpackage

// File: rtl/pit_prescale.sv
// Power-of-two prescaler: emits a tick once per 2^pit_pre_scl enabled cycles.
module pit_prescale
  import pit_pkg::*;
(
  input  logic                 bus_clk,
  input  logic                 async_rst_b,
  input  logic                 sync_reset,
  input  logic                 en,
  input  logic [3:0]           pit_pre_scl,
  output logic                 tick,
  output logic [PRE_CNT_W-1:0] pre_cnt
);

  // >= rather than == so a shrinking divisor wraps immediately instead of
  // running all the way around the 15-bit counter.
  assign tick = en && (pre_cnt >= div_m1(pit_pre_scl));

  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      pre_cnt <= '0;
    end else if (sync_reset || !en || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pit_count.sv
// Programmable interval timer: prescaled modulo counter with rollover pulse and sticky flag.
module pit_count
  import pit_pkg::*;
#(
  parameter int COUNT_SIZE  = 16,
  parameter bit NO_PRESCALE = 1'b0
) (
  input  logic                  bus_clk,
  input  logic                  async_rst_b,
  input  logic                  sync_reset,
  input  logic [COUNT_SIZE-1:0] mod_value,
  input  logic [3:0]            pit_pre_scl,
  input  logic                  pit_slave,
  input  logic                  cnt_sync_o,
  input  logic                  ext_sync_i,
  input  logic                  pit_flg_clr,
  output logic [COUNT_SIZE-1:0] cnt_n,
  output logic                  cnt_flag_o,
  output logic                  pit_o
);

  logic                  en;
  logic                  tick;
  logic                  rollover;
  logic [PRE_CNT_W-1:0]  pre_cnt;
  logic [COUNT_SIZE-1:0] term;

  assign en = pit_slave ? ext_sync_i : cnt_sync_o;

  generate
    if (NO_PRESCALE) begin : g_no_pre
      assign tick    = en;
      assign pre_cnt = '0;
    end else begin : g_pre
      pit_prescale u_prescale (
        .bus_clk     (bus_clk),
        .async_rst_b (async_rst_b),
        .sync_reset  (sync_reset),
        .en          (en),
        .pit_pre_scl (pit_pre_scl),
        .tick        (tick),
        .pre_cnt     (pre_cnt)
      );
    end
  endgenerate

  // A modulus of zero means the full 2^COUNT_SIZE range.
  assign term     = (mod_value == '0) ? '1 : mod_value - 1'b1;
  assign rollover = tick && (cnt_n >= term);

  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      cnt_n      <= '0;
      cnt_flag_o <= 1'b0;
      pit_o      <= 1'b0;
    end else if (sync_reset) begin
      cnt_n      <= '0;
      cnt_flag_o <= 1'b0;
      pit_o      <= 1'b0;
    end else begin
      pit_o <= rollover;
      if (!en || rollover) begin
        cnt_n <= '0;
      end else if (tick) begin
        cnt_n <= cnt_n + 1'b1;
      end
      if (rollover) begin
        cnt_flag_o <= 1'b1;
      end else if (pit_flg_clr) begin
        cnt_flag_o <= 1'b0;
      end
    end
  end

  // Every prescale tick restarts the prescale period.
  a_tick_restarts : assert property (@(posedge bus_clk) disable iff (!async_rst_b)
                                     tick |=> (pre_cnt == '0));

endmodule
